// File: rtl/adc_pixel_sequencer_pkg.sv
// rtl/adc_pixel_sequencer_pkg.sv - shared states, defaults and XADC constants for the pixel sequencer
package adc_pixel_sequencer_pkg;

    localparam int NB_DATA_DEF  = 12;
    localparam int NB_ADDR_DEF  = 10;
    localparam int LOG2_AVG_DEF = 2;
    localparam int TIMEOUT_DEF  = 255;

    // DRP channel address of the vaux6 input feeding the speckle photodiode
    localparam logic [6:0] XADC_CH_VAUX6 = 7'h16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_TRIG,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/adc_pixel_sequencer_if.sv
// rtl/adc_pixel_sequencer_if.sv - XADC handshake and frame RAM write port of the pixel sequencer
interface adc_pixel_sequencer_if
    import adc_pixel_sequencer_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF
);
    logic               o_adc_trigger;
    logic [NB_DATA-1:0] i_adc_val;
    logic               i_adc_done;
    logic               o_ram_we;
    logic [NB_ADDR-1:0] o_ram_addr;
    logic [NB_DATA-1:0] o_ram_data;
    logic [NB_DATA-1:0] last_sample;

    modport master (
        output o_adc_trigger, o_ram_we, o_ram_addr, o_ram_data, last_sample,
        input  i_adc_val, i_adc_done
    );

    modport slave (
        input  o_adc_trigger, o_ram_we, o_ram_addr, o_ram_data, last_sample,
        output i_adc_val, i_adc_done
    );
endinterface

// File: rtl/adc_avg_accum.sv
// rtl/adc_avg_accum.sv - sample accumulator and counter; average is the truncated mean
module adc_avg_accum
    import adc_pixel_sequencer_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int LOG2_AVG = LOG2_AVG_DEF
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                acc_en,
    input  logic [NB_DATA-1:0]  sample,
    output logic [LOG2_AVG:0]   count,
    output logic [NB_DATA-1:0]  avg,
    output logic [NB_DATA-1:0]  last_sample
);
    localparam int ACC_W = NB_DATA + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;

    logic [ACC_W-1:0] acc;

    // LOG2_AVG guard bits make overflow impossible for 2^LOG2_AVG samples
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc   <= '0;
            count <= '0;
        end else if (acc_en) begin
            acc   <= acc + ACC_W'(sample);
            count <= count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_sample <= '0;
        end else if (acc_en) begin
            last_sample <= sample;
        end
    end

    assign avg = acc[ACC_W-1:LOG2_AVG];

endmodule

// File: rtl/adc_pixel_sequencer.sv
// rtl/adc_pixel_sequencer.sv - settle, oversample via XADC, threshold and store one pixel
module adc_pixel_sequencer
    import adc_pixel_sequencer_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int NB_ADDR  = NB_ADDR_DEF,
    parameter int LOG2_AVG = LOG2_AVG_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [NB_ADDR-1:0]  i_addr,
    input  logic [15:0]         i_settle,
    input  logic [NB_DATA-1:0]  i_umbral,
    output logic                o_busy,
    output logic                o_pixel_bit,
    output logic                o_done,
    output logic                o_timeout,
    adc_pixel_sequencer_if.master bus
);
    localparam int                CNT_W    = LOG2_AVG + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'((1 << LOG2_AVG) - 1);
    localparam int                TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT);

    seq_state_t         state;
    seq_state_t         next_state;
    logic [15:0]        settle_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [NB_DATA-1:0] umbral_q;
    logic [CNT_W-1:0]   count;
    logic [NB_DATA-1:0] avg;
    logic               capture;
    logic               acc_en;
    logic               timeout_hit;

    adc_avg_accum #(
        .NB_DATA  (NB_DATA),
        .LOG2_AVG (LOG2_AVG)
    ) u_accum (
        .clk         (clk),
        .rst         (rst),
        .clr         (capture),
        .acc_en      (acc_en),
        .sample      (bus.i_adc_val),
        .count       (count),
        .avg         (avg),
        .last_sample (bus.last_sample)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Timeout wins over a late done: TIMEOUT whole WAIT cycles is the hard limit
    always_comb begin
        next_state  = state;
        capture     = 1'b0;
        acc_en      = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_req) begin
                    capture    = 1'b1;
                    next_state = (i_settle == 16'd0) ? ST_TRIG : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == 16'd1) begin
                    next_state = ST_TRIG;
                end
            end
            ST_TRIG:  next_state = ST_WAIT;
            ST_WAIT: begin
                if (tmo_cnt == TMO_MAX) begin
                    timeout_hit = 1'b1;
                    next_state  = ST_DONE;
                end else if (bus.i_adc_done) begin
                    acc_en     = 1'b1;
                    next_state = (count == LAST_CNT) ? ST_WRITE : ST_TRIG;
                end
            end
            ST_WRITE: next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt        <= '0;
            tmo_cnt           <= '0;
            umbral_q          <= '0;
            bus.o_ram_addr    <= '0;
            bus.o_adc_trigger <= 1'b0;
            bus.o_ram_we      <= 1'b0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_timeout         <= 1'b0;
            o_pixel_bit       <= 1'b0;
        end else begin
            if (capture) begin
                settle_cnt     <= i_settle;
                umbral_q       <= i_umbral;
                bus.o_ram_addr <= i_addr;
            end else if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt - 16'd1;
            end
            if (state == ST_TRIG) begin
                tmo_cnt <= '0;
            end else if (state == ST_WAIT && !timeout_hit) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (state == ST_WRITE) begin
                o_pixel_bit <= (avg >= umbral_q);
            end
            bus.o_adc_trigger <= (next_state == ST_TRIG);
            bus.o_ram_we      <= (next_state == ST_WRITE);
            o_busy            <= (next_state != ST_IDLE);
            o_done            <= (next_state == ST_DONE);
            o_timeout         <= timeout_hit;
        end
    end

    // The accumulator is already final when WRITE is entered
    assign bus.o_ram_data = avg;

endmodule

// File: tb/tb_adc_pixel_sequencer.sv
// tb/tb_adc_pixel_sequencer.sv - directed bench for adc_pixel_sequencer with cycle-exact XADC model
module tb_adc_pixel_sequencer;
    localparam int NB_DATA = 12;
    localparam int NB_ADDR = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               req, req2;
    logic [NB_ADDR-1:0] addr;
    logic [15:0]        settle;
    logic [NB_DATA-1:0] umbral;
    logic busy, pix, done, tmo;
    logic busy2, pix2, done2, tmo2;

    adc_pixel_sequencer_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) b1 ();
    adc_pixel_sequencer_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) b2 ();

    adc_pixel_sequencer #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .LOG2_AVG(2), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .i_req(req), .i_addr(addr), .i_settle(settle), .i_umbral(umbral),
        .o_busy(busy), .o_pixel_bit(pix), .o_done(done), .o_timeout(tmo), .bus(b1)
    );

    adc_pixel_sequencer #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .LOG2_AVG(4), .TIMEOUT(20)) dut2 (
        .clk(clk), .rst(rst), .i_req(req2), .i_addr(addr), .i_settle(settle), .i_umbral(umbral),
        .o_busy(busy2), .o_pixel_bit(pix2), .o_done(done2), .o_timeout(tmo2), .bus(b2)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int cyc, dly, rem1, rem2, vidx;
    bit hang, spur_trig, spur_idle;
    logic [NB_DATA-1:0] vals [0:15];
    int trig_cyc [$];
    int we_cnt, we_cyc, done_cyc, busy_lo, we2, done2_cyc;
    logic [NB_DATA-1:0] ram_data_q, data2;
    logic [NB_ADDR-1:0] ram_addr_q;
    logic tmo_q;

    // One cycle: runs both XADC models and records DUT events at the negedge
    task automatic tick();
        @(negedge clk);
        cyc++;
        b1.i_adc_done = 1'b0;
        if (spur_idle) begin
            b1.i_adc_done = 1'b1;
            b1.i_adc_val  = 12'hFFF;
        end
        if (b1.o_adc_trigger) begin
            trig_cyc.push_back(cyc);
            rem1 = hang ? 0 : dly;
            if (spur_trig) begin
                b1.i_adc_done = 1'b1;
                b1.i_adc_val  = 12'hFFF;
            end
        end else if (rem1 > 0) begin
            rem1--;
            if (rem1 == 0) begin
                b1.i_adc_done = 1'b1;
                b1.i_adc_val  = vals[vidx];
                vidx = (vidx + 1) % 16;
            end
        end
        b2.i_adc_done = 1'b0;
        if (b2.o_adc_trigger) begin
            rem2 = 2;
        end else if (rem2 > 0) begin
            rem2--;
            if (rem2 == 0) begin
                b2.i_adc_done = 1'b1;
                b2.i_adc_val  = 12'hFFF;
            end
        end
        if (b1.o_ram_we) begin
            we_cnt++;
            we_cyc     = cyc;
            ram_data_q = b1.o_ram_data;
            ram_addr_q = b1.o_ram_addr;
        end
        if (done) begin
            done_cyc = cyc;
            tmo_q    = tmo;
        end
        if (b2.o_ram_we) begin
            we2++;
            data2 = b2.o_ram_data;
        end
        if (done2) done2_cyc = cyc;
    endtask

    task automatic set_vals(input int base, input int step);
        for (int i = 0; i < 16; i++) vals[i] = NB_DATA'(base + step * i);
    endtask

    task automatic acquire(input int a, input int s, input int u, input bit hold_req, input int budget);
        tick();
        addr = NB_ADDR'(a); settle = 16'(s); umbral = NB_DATA'(u); req = 1'b1;
        spur_idle = 1'b0;
        cyc = 0; trig_cyc.delete(); we_cnt = 0; we_cyc = -1; done_cyc = -1; tmo_q = 1'b0;
        vidx = 0; busy_lo = 0;
        while (done_cyc < 0 && cyc < budget) begin
            tick();
            if (!hold_req) req = 1'b0;
            if (!busy) busy_lo++;
        end
        req = 1'b0;
        if (done_cyc < 0) check_eq("done_within_budget", 0, 1);
    endtask

    initial begin
        req = 0; req2 = 0; addr = 0; settle = 0; umbral = 0;
        b1.i_adc_done = 0; b1.i_adc_val = 0; b2.i_adc_done = 0; b2.i_adc_val = 0;
        cyc = 0; dly = 4; rem1 = 0; rem2 = 0; vidx = 0; hang = 0; spur_trig = 0; spur_idle = 0;
        we2 = 0; done2_cyc = -1; data2 = 0;
        set_vals(100, 1);

        repeat (3) tick();
        check_eq("rst_flags", {26'd0, busy, b1.o_adc_trigger, b1.o_ram_we, done, tmo, pix}, 0);
        check_eq("rst_ram_addr", b1.o_ram_addr, 0);
        check_eq("rst_ram_data", b1.o_ram_data, 0);
        rst = 1'b0;

        // Four samples 100..103, settle 0, C=4
        acquire(5, 0, 50, 0, 100);
        check_eq("t1_ntrig", trig_cyc.size(), 4);
        for (int k = 0; k < 4 && k < trig_cyc.size(); k++) check_eq("t1_trig_cyc", trig_cyc[k], 1 + 5 * k);
        check_eq("t1_ram_data", ram_data_q, 101);
        check_eq("t1_ram_addr", ram_addr_q, 5);
        check_eq("t1_we_cyc", we_cyc, 21);
        check_eq("t1_we_cnt", we_cnt, 1);
        check_eq("t1_done_cyc", done_cyc, 22);
        check_eq("t1_timeout", tmo_q, 0);
        check_eq("t1_pixel", pix, 1);
        check_eq("t1_last_sample", b1.last_sample, 103);
        check_eq("t1_busy_gap", busy_lo, 0);
        tick();
        check_eq("t1_idle_busy", busy, 0);

        // Settle 10, constant 101 against thresholds 102 then 101
        set_vals(101, 0);
        acquire(6, 10, 102, 0, 100);
        check_eq("t2_first_trig", (trig_cyc.size() > 0) ? trig_cyc[0] : -1, 11);
        check_eq("t2_done_cyc", done_cyc, 32);
        check_eq("t2_pixel_lt", pix, 0);
        acquire(6, 10, 101, 0, 100);
        check_eq("t2_pixel_eq", pix, 1);

        // Hung conversion
        hang = 1'b1;
        acquire(7, 0, 0, 0, 400);
        check_eq("t3_done_cyc", done_cyc, 1 + 257);
        check_eq("t3_timeout", tmo_q, 1);
        check_eq("t3_we_cnt", we_cnt, 0);
        check_eq("t3_ntrig", trig_cyc.size(), 1);
        check_eq("t3_pixel_held", pix, 1);
        hang = 1'b0;

        // Done exactly TIMEOUT cycles after each trigger, spurious dones in IDLE and TRIG
        dly = 255; set_vals(200, 0); spur_idle = 1'b1; spur_trig = 1'b1;
        acquire(8, 0, 201, 0, 1200);
        spur_trig = 1'b0;
        check_eq("t4_timeout", tmo_q, 0);
        check_eq("t4_ram_data", ram_data_q, 200);
        check_eq("t4_we_cyc", we_cyc, 1025);
        check_eq("t4_done_cyc", done_cyc, 1026);
        check_eq("t4_pixel", pix, 0);

        // i_req held high through the whole acquisition
        dly = 4; set_vals(100, 1);
        acquire(9, 0, 50, 1, 100);
        check_eq("t5_ntrig", trig_cyc.size(), 4);
        check_eq("t5_we_cnt", we_cnt, 1);
        check_eq("t5_done_cyc", done_cyc, 22);
        tick(); tick();
        check_eq("t5_no_restart", busy, 0);

        // Reset in the middle of WAIT, then a clean run
        set_vals(500, 0);
        tick(); addr = 10'd33; settle = 0; req = 1'b1; cyc = 0;
        repeat (8) begin tick(); req = 1'b0; end
        rst = 1'b1;
        tick();
        check_eq("t6_rst_flags", {26'd0, busy, b1.o_adc_trigger, b1.o_ram_we, done, tmo, pix}, 0);
        check_eq("t6_rst_ram_data", b1.o_ram_data, 0);
        check_eq("t6_rst_ram_addr", b1.o_ram_addr, 0);
        rst = 1'b0; rem1 = 0;
        set_vals(100, 1);
        acquire(12, 0, 50, 0, 100);
        check_eq("t6_ram_data", ram_data_q, 101);
        check_eq("t6_done_cyc", done_cyc, 22);

        // Full-scale samples with 16x averaging
        settle = 0; umbral = 12'hFFF; we2 = 0; done2_cyc = -1;
        tick(); req2 = 1'b1; cyc = 0;
        tick(); req2 = 1'b0;
        while (done2_cyc < 0 && cyc < 200) tick();
        check_eq("t7_done_cyc", done2_cyc, 16 * 3 + 2);
        check_eq("t7_we_cnt", we2, 1);
        check_eq("t7_ram_data", data2, 12'hFFF);
        check_eq("t7_pixel", pix2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
